// File: rtl/exwb_pipe_reg_pkg.sv
// rtl/exwb_pipe_reg_pkg.sv - shared pipeline types and opcode constants
//
// Purpose: EX/WB result struct, architectural register count and the opcode
//          constants used by the writeback destination decode.
// Ports:   none (package).
package exwb_pipe_reg_pkg;

  localparam int NUM_ARCH_REGS = 16;

  typedef struct packed {
    logic [31:0] pc_contents;
    logic [31:0] alu_result;
    logic [31:0] alu_ext_result;
    logic [7:0]  ctl_opcode;
    logic        twob_opcode;
    logic [7:0]  ctl_regByte;
    logic [7:0]  ctl_rmByte;
    logic        sim_end;
    logic [1:0]  mod;
  } EX_WB;

  localparam logic [7:0] OP_NOP     = 8'd144;
  localparam logic [7:0] OP_CMP     = 8'd57;
  localparam logic [7:0] OP_IMUL    = 8'd247;
  localparam logic [7:0] OP_IMUL_2B = 8'd175;
  localparam logic [7:0] OP_SYSCALL = 8'd5;
  localparam logic [7:0] OP_CALL    = 8'd232;
  localparam logic [7:0] OP_GRP5    = 8'd255;
  localparam logic [7:0] OP_RET     = 8'd195;
  localparam logic [7:0] OP_PUSH_LO = 8'd80;
  localparam logic [7:0] OP_PUSH_HI = 8'd87;
  localparam logic [7:0] OP_POP_LO  = 8'd88;
  localparam logic [7:0] OP_POP_HI  = 8'd95;
  localparam logic [7:0] OP_MOV_ST  = 8'd137;
  localparam logic [7:0] OP_MOV_LD  = 8'd139;
  localparam logic [7:0] OP_LEA     = 8'd141;
  localparam logic [7:0] OP_MOVI_LO = 8'd184;
  localparam logic [7:0] OP_MOVI_HI = 8'd191;

  // Implicit destinations: syscall result, IMUL high half, stack pointer.
  localparam int REG_SYSCALL  = 0;
  localparam int REG_IMUL_HI  = 2;
  localparam int REG_SP       = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/exwb_dst_decode.sv
// rtl/exwb_dst_decode.sv - destination register mask decode for one EX/WB entry
//
// Purpose: one-hot OR of architectural registers the entry will write.
// Ports:   opcode, twob_opcode, reg_idx/rm_idx (low nibbles of regByte/rmByte),
//          mod  -> mask[0:NREGS-1] (bit i = register i).
import exwb_pipe_reg_pkg::*;

module exwb_dst_decode #(
  parameter int NREGS = NUM_ARCH_REGS
) (
  input  logic [7:0]       opcode,
  input  logic             twob_opcode,
  input  logic [3:0]       reg_idx,
  input  logic [3:0]       rm_idx,
  input  logic [1:0]       mod,
  output logic [0:NREGS-1] mask
);

  logic use_reg;
  logic use_rm;
  logic use_r0;
  logic use_r2;
  logic use_sp;

  // Priority order matters: the two-byte filter must precede the IMUL match
  // so that only the two-byte form of 175 reaches it.
  always_comb begin
    use_reg = 1'b0;
    use_rm  = 1'b0;
    use_r0  = 1'b0;
    use_r2  = 1'b0;
    use_sp  = 1'b0;
    if (opcode == OP_NOP || opcode == OP_CMP) begin
    end else if (twob_opcode && opcode != OP_IMUL_2B) begin
    end else if (opcode == OP_IMUL || (opcode == OP_IMUL_2B && twob_opcode)) begin
      use_reg = 1'b1;
      use_r2  = 1'b1;
    end else if (opcode == OP_SYSCALL) begin
      use_r0 = 1'b1;
    end else if (opcode == OP_GRP5 || opcode == OP_CALL || opcode == OP_RET ||
                 (opcode >= OP_PUSH_LO && opcode <= OP_PUSH_HI)) begin
      use_sp = 1'b1;
    end else if (opcode >= OP_POP_LO && opcode <= OP_POP_HI) begin
      use_sp = 1'b1;
      use_rm = 1'b1;
    end else if (opcode == OP_MOV_ST) begin
      // Stores only write a register in register-direct form.
      use_rm = (mod == 2'b11);
    end else if (opcode == OP_MOV_LD || opcode == OP_LEA) begin
      use_reg = 1'b1;
    end else begin
      // MOVI range and every other opcode target rmByte.
      use_rm = 1'b1;
    end
  end

  // Indices at or above NREGS simply never match a mask bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREGS; i++) begin
      mask[i] = (use_reg && int'(reg_idx) == i) ||
                (use_rm  && int'(rm_idx)  == i) ||
                (use_r0  && i == REG_SYSCALL)   ||
                (use_r2  && i == REG_IMUL_HI)   ||
                (use_sp  && i == REG_SP);
    end
  end

endmodule

// File: rtl/exwb_pipe_reg.sv
// rtl/exwb_pipe_reg.sv - two-entry EX/WB pipeline register with skid buffer
//
// Purpose: decouples execute from writeback; main register is always the
//          head, skid register absorbs one extra result under backpressure.
// Ports:   clk, reset (sync, active-high)
//          ex_valid/ex_data/ex_ready : execute-side handshake
//          flush                     : drop all held entries
//          wb_ready/can_writeback/exwb : writeback-side handshake, head entry
//          pending_dst               : registers written by held entries
//          halted                    : sim_end accepted, intake closed
import exwb_pipe_reg_pkg::*;

module exwb_pipe_reg #(
  parameter int NREGS = NUM_ARCH_REGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  EX_WB             ex_data,
  output logic             ex_ready,
  input  logic             flush,
  input  logic             wb_ready,
  output logic             can_writeback,
  output EX_WB             exwb,
  output logic [0:NREGS-1] pending_dst,
  output logic             halted
);

  occ_state_t state;
  occ_state_t state_next;
  EX_WB       main_q;
  EX_WB       skid_q;
  logic       ex_ready_q;
  logic       halted_q;
  logic       halted_next;
  logic       accept;
  logic       pop;
  logic       load_main_new;
  logic       load_main_skid;
  logic       load_skid_new;
  logic [0:NREGS-1] main_mask;
  logic [0:NREGS-1] skid_mask;

  assign ex_ready      = ex_ready_q;
  assign halted        = halted_q;
  assign can_writeback = (state != EMPTY);
  assign exwb          = main_q;
  assign accept        = ex_valid && ex_ready_q;
  assign pop           = can_writeback && wb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    halted_next    = halted_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid_new  = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      if (accept && ex_data.sim_end) begin
        halted_next = 1'b1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next    = ONE;
            load_main_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            state_next    = FULL;
            load_skid_new = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // ex_ready is low in FULL, so only a pop can happen here.
          if (pop) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // ex_ready is computed from next-state so it is a flop output and never
  // combinationally depends on wb_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      halted_q   <= 1'b0;
      ex_ready_q <= 1'b1;
    end else begin
      halted_q   <= halted_next;
      ex_ready_q <= (state_next != FULL) && !halted_next;
      if (load_main_new) begin
        main_q <= ex_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_new) begin
        skid_q <= ex_data;
      end
    end
  end

  exwb_dst_decode #(.NREGS(NREGS)) u_dst_main (
    .opcode      (main_q.ctl_opcode),
    .twob_opcode (main_q.twob_opcode),
    .reg_idx     (main_q.ctl_regByte[3:0]),
    .rm_idx      (main_q.ctl_rmByte[3:0]),
    .mod         (main_q.mod),
    .mask        (main_mask)
  );

  exwb_dst_decode #(.NREGS(NREGS)) u_dst_skid (
    .opcode      (skid_q.ctl_opcode),
    .twob_opcode (skid_q.twob_opcode),
    .reg_idx     (skid_q.ctl_regByte[3:0]),
    .rm_idx      (skid_q.ctl_rmByte[3:0]),
    .mod         (skid_q.mod),
    .mask        (skid_mask)
  );

  assign pending_dst = ((state != EMPTY) ? main_mask : '0) |
                       ((state == FULL)  ? skid_mask : '0);

endmodule

// File: tb/tb_exwb_pipe_reg.sv
// tb/tb_exwb_pipe_reg.sv - self-checking bench for exwb_pipe_reg
import exwb_pipe_reg_pkg::*;

module tb_exwb_pipe_reg;

  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  EX_WB          ex_data = '0;
  logic          ex_ready;
  logic          flush = 1'b0;
  logic          wb_ready = 1'b0;
  logic          can_writeback;
  EX_WB          exwb;
  logic [0:NR-1] pending_dst;
  logic          halted;

  int checks = 0;
  int failures = 0;

  EX_WB sb[$];
  logic m_halted = 1'b0;

  exwb_pipe_reg #(.NREGS(NR)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_data(ex_data),
    .ex_ready(ex_ready), .flush(flush), .wb_ready(wb_ready),
    .can_writeback(can_writeback), .exwb(exwb), .pending_dst(pending_dst),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic EX_WB mk(input logic [7:0] op, input logic tb2,
                              input logic [7:0] rg, input logic [7:0] rm,
                              input logic [1:0] md, input logic se);
    EX_WB e;
    e.pc_contents    = $urandom;
    e.alu_result     = $urandom;
    e.alu_ext_result = $urandom;
    e.ctl_opcode     = op;
    e.twob_opcode    = tb2;
    e.ctl_regByte    = rg;
    e.ctl_rmByte     = rm;
    e.sim_end        = se;
    e.mod            = md;
    return e;
  endfunction

  function automatic logic [0:NR-1] bits(input int a, input int b);
    logic [0:NR-1] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    return m;
  endfunction

  // Drive one cycle; the scoreboard queue models held entries (push on
  // accept, pop on writeback) from the bench's own view of occupancy.
  task automatic tick(input logic v, input EX_WB d, input logic wr,
                      input logic fl, input logic rs);
    logic acc;
    logic pp;
    ex_valid = v; ex_data = d; wb_ready = wr; flush = fl; reset = rs;
    acc = v && (sb.size() < 2) && !m_halted;
    pp  = wr && (sb.size() > 0);
    @(posedge clk); #1;
    if (rs) begin
      sb.delete(); m_halted = 1'b0;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (pp) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(d);
        if (d.sim_end) m_halted = 1'b1;
      end
    end
    ex_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset;
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL rst_cwb got=%b exp=0", can_writeback); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ex_ready); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (pending_dst !== '0) begin failures++; $display("FAIL rst_pending got=%h exp=0", pending_dst); end
    checks++; if (exwb !== '0) begin failures++; $display("FAIL rst_exwb got=%h exp=0", exwb); end
  endtask

  task automatic test_single_pass;
    EX_WB a;
    a = mk(8'd139, 1'b0, 8'd3, 8'd9, 2'd0, 1'b0);
    tick(1'b1, a, 1'b1, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b1) begin failures++; $display("FAIL sp_cwb got=%b exp=1", can_writeback); end
    checks++; if (exwb !== a) begin failures++; $display("FAIL sp_exwb got=%h exp=%h", exwb, a); end
    checks++; if (pending_dst !== bits(3, -1)) begin failures++; $display("FAIL sp_pending got=%h exp=%h", pending_dst, bits(3, -1)); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL sp_empty got=%b exp=0", can_writeback); end
    checks++; if (pending_dst !== '0) begin failures++; $display("FAIL sp_pending0 got=%h exp=0", pending_dst); end
  endtask

  task automatic test_backpressure;
    EX_WB a;
    EX_WB b;
    a = mk(8'd139, 1'b0, 8'd1, 8'd0, 2'd0, 1'b0);
    b = mk(8'd184, 1'b0, 8'd0, 8'd7, 2'd0, 1'b0);
    tick(1'b1, a, 1'b0, 1'b0, 1'b0);
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", ex_ready); end
    tick(1'b1, b, 1'b0, 1'b0, 1'b0);
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", ex_ready); end
    checks++; if (pending_dst !== bits(1, 7)) begin failures++; $display("FAIL bp_pending got=%h exp=%h", pending_dst, bits(1, 7)); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (exwb !== a) begin failures++; $display("FAIL bp_stall%0d got=%h exp=%h", i, exwb, a); end
    end
    checks++; if (exwb !== sb[0]) begin failures++; $display("FAIL bp_head_a got=%h exp=%h", exwb, sb[0]); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (exwb !== b) begin failures++; $display("FAIL bp_head_b got=%h exp=%h", exwb, b); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", ex_ready); end
    checks++; if (pending_dst !== bits(7, -1)) begin failures++; $display("FAIL bp_pending_b got=%h exp=%h", pending_dst, bits(7, -1)); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", can_writeback); end
  endtask

  task automatic test_simultaneous;
    EX_WB a;
    EX_WB b;
    a = mk(8'd5, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
    b = mk(8'd232, 1'b0, 8'd0, 8'd0, 2'd0, 1'b0);
    tick(1'b1, a, 1'b0, 1'b0, 1'b0);
    tick(1'b1, b, 1'b1, 1'b0, 1'b0);
    checks++; if (exwb !== b) begin failures++; $display("FAIL sim_exwb got=%h exp=%h", exwb, b); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", ex_ready); end
    checks++; if (pending_dst !== bits(4, -1)) begin failures++; $display("FAIL sim_pending got=%h exp=%h", pending_dst, bits(4, -1)); end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL sim_one got=%b exp=0", can_writeback); end
  endtask

  task automatic test_flush;
    EX_WB c;
    c = mk(8'd139, 1'b0, 8'd6, 8'd0, 2'd0, 1'b0);
    tick(1'b1, mk(8'd88, 1'b0, 8'd0, 8'd1, 2'd0, 1'b0), 1'b0, 1'b0, 1'b0);
    tick(1'b1, mk(8'd88, 1'b0, 8'd0, 8'd2, 2'd0, 1'b0), 1'b0, 1'b0, 1'b0);
    tick(1'b1, c, 1'b0, 1'b1, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL fl_cwb got=%b exp=0", can_writeback); end
    checks++; if (pending_dst !== '0) begin failures++; $display("FAIL fl_pending got=%h exp=0", pending_dst); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", ex_ready); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%b exp=0", can_writeback); end
  endtask

  task automatic test_halt;
    EX_WB a;
    EX_WB b;
    a = mk(8'd1, 1'b0, 8'd0, 8'd3, 2'd0, 1'b1);
    b = mk(8'd1, 1'b0, 8'd0, 8'd8, 2'd0, 1'b0);
    tick(1'b1, a, 1'b0, 1'b0, 1'b0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL h_halted got=%b exp=1", halted); end
    checks++; if (ex_ready !== 1'b0) begin failures++; $display("FAIL h_ready got=%b exp=0", ex_ready); end
    tick(1'b1, b, 1'b0, 1'b0, 1'b0);
    checks++; if (exwb !== a) begin failures++; $display("FAIL h_head got=%h exp=%h", exwb, a); end
    checks++; if (pending_dst !== bits(3, -1)) begin failures++; $display("FAIL h_pending got=%h exp=%h", pending_dst, bits(3, -1)); end
    tick(1'b1, b, 1'b1, 1'b0, 1'b0);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL h_drain got=%b exp=0", can_writeback); end
    tick(1'b1, b, 1'b1, 1'b1, 1'b0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL h_flush_keeps got=%b exp=1", halted); end
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL h_no_accept got=%b exp=0", can_writeback); end
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (halted !== 1'b0 || ex_ready !== 1'b1) begin failures++; $display("FAIL h_reset got=%b/%b exp=0/1", halted, ex_ready); end
  endtask

  task automatic test_reset_full;
    tick(1'b1, mk(8'd139, 1'b0, 8'd5, 8'd0, 2'd0, 1'b0), 1'b0, 1'b0, 1'b0);
    tick(1'b1, mk(8'd1, 1'b0, 8'd0, 8'd9, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL rf_pre_halted got=%b exp=1", halted); end
    tick(1'b1, mk(8'd139, 1'b0, 8'd6, 8'd0, 2'd0, 1'b0), 1'b1, 1'b1, 1'b1);
    checks++; if (can_writeback !== 1'b0) begin failures++; $display("FAIL rf_cwb got=%b exp=0", can_writeback); end
    checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL rf_ready got=%b exp=1", ex_ready); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rf_halted got=%b exp=0", halted); end
    checks++; if (pending_dst !== '0) begin failures++; $display("FAIL rf_pending got=%h exp=0", pending_dst); end
    checks++; if (exwb !== '0) begin failures++; $display("FAIL rf_exwb got=%h exp=0", exwb); end
  endtask

  typedef struct {
    logic [7:0] op;
    logic       tb2;
    logic [7:0] rg;
    logic [7:0] rm;
    logic [1:0] md;
    int         b0;
    int         b1;
  } dec_vec_t;

  task automatic test_mask_decode;
    dec_vec_t vec[12];
    logic [0:NR-1] exp;
    vec[0]  = '{8'd247, 1'b0, 8'd1,    8'd0,    2'd0, 1, 2};
    vec[1]  = '{8'd88,  1'b0, 8'd0,    8'd5,    2'd0, 4, 5};
    vec[2]  = '{8'd137, 1'b0, 8'd2,    8'd3,    2'd0, -1, -1};
    vec[3]  = '{8'd137, 1'b0, 8'd2,    8'd3,    2'd3, 3, -1};
    vec[4]  = '{8'd144, 1'b0, 8'd2,    8'd2,    2'd3, -1, -1};
    vec[5]  = '{8'd5,   1'b0, 8'd7,    8'd7,    2'd3, 0, -1};
    vec[6]  = '{8'd175, 1'b1, 8'd9,    8'd1,    2'd3, 9, 2};
    vec[7]  = '{8'd175, 1'b0, 8'd9,    8'd6,    2'd3, 6, -1};
    vec[8]  = '{8'd139, 1'b1, 8'd3,    8'd3,    2'd3, -1, -1};
    vec[9]  = '{8'd232, 1'b0, 8'd1,    8'd1,    2'd3, 4, -1};
    vec[10] = '{8'd141, 1'b0, 8'h26,   8'd1,    2'd0, 6, -1};
    vec[11] = '{8'd189, 1'b0, 8'd0,    8'hFB,   2'd0, 11, -1};
    for (int i = 0; i < 12; i++) begin
      exp = bits(vec[i].b0, vec[i].b1);
      tick(1'b1, mk(vec[i].op, vec[i].tb2, vec[i].rg, vec[i].rm, vec[i].md, 1'b0),
           1'b0, 1'b0, 1'b0);
      checks++; if (pending_dst !== exp) begin failures++; $display("FAIL dec%0d_op%0d got=%h exp=%h", i, vec[i].op, pending_dst, exp); end
      tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_halt();
    test_reset_full();
    test_mask_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exwb_pipe_reg.md
EXWB_PIPE_REG -- requirements
Module: exwb_pipe_reg

Interface
REQ-001 SHALL take parameter NREGS, default 16: architectural register count, which sizes pending_dst.
REQ-002 SHALL have one clock and a synchronous, active-high reset. Ports, one per line:
  clk  in  1  sole clock; all state updates on posedge
  reset  in  1  synchronous, active-high
  ex_valid  in  1  execute stage presents a result
  ex_data  in  EX_WB  result struct (pc_contents, alu_result, alu_ext_result, ctl_opcode, twob_opcode, ctl_regByte, ctl_rmByte, sim_end, mod)
  ex_ready  out  1  block accepts ex_data this cycle
  flush  in  1  discard all held entries
  wb_ready  in  1  writeback consumes the head entry this cycle
  can_writeback  out  1  head entry valid
  exwb  out  EX_WB  head entry
  pending_dst  out  [0:NREGS-1]  one-hot OR of registers written by held entries
  halted  out  1  sim_end entry accepted; intake closed

Function
REQ-003 SHALL hold up to 2 entries, as a main register plus a skid register; exwb SHALL always present the main register.
REQ-004 SHALL use states EMPTY, ONE and FULL, with occupancy 0, 1 and 2.
REQ-005 SHALL drive ex_ready = (state != FULL) && !halted, registered so that it does not depend combinationally on wb_ready.
REQ-006 SHALL treat an accept as ex_valid && ex_ready, and a pop as can_writeback && wb_ready.
REQ-007 SHALL apply these transitions:
  EMPTY: accept -> ONE.
  ONE: accept only -> FULL; pop only -> EMPTY; accept and pop -> ONE, loading new data into main.
  FULL: pop -> ONE, with skid moving to main.
REQ-008 SHALL have 1-cycle latency: data accepted in cycle N is visible on exwb in cycle N+1 when the block was EMPTY.
REQ-009 SHALL keep exwb stable while can_writeback=1 and wb_ready=0.
REQ-010 SHALL make flush dominant: next state EMPTY, simultaneous accept ignored, halted unchanged.
REQ-011 SHALL set halted when an entry with sim_end=1 is accepted, and keep it set until reset; entries already held SHALL still drain.
REQ-012 SHALL compute the destination mask per entry, combinationally, as follows:
  opcode 144 or 57 -> none.
  twob_opcode=1 and opcode not 175 -> none.
  247, or 175 with twob_opcode -> regByte plus reg 2.
  5 -> reg 0.
  255, 232, 195, 80-87 -> reg 4.
  88-95 -> reg 4 plus rmByte.
  137 with mod=3 -> rmByte.
  137 with mod!=3 -> none.
  139, or 141 without twob_opcode -> regByte.
  184-191 -> rmByte.
  all other opcodes -> rmByte.
REQ-013 SHALL drive pending_dst as the OR of the masks of valid entries only, and SHALL make it 0 in EMPTY.
REQ-014 SHALL use only the low 4 bits of regByte and rmByte; indices >= NREGS SHALL contribute nothing.

Reset
REQ-015 SHALL, on reset, drive state=EMPTY, can_writeback=0, ex_ready=1 (from the next cycle), halted=0, pending_dst=0 and exwb=all zeros.
REQ-016 SHALL give reset priority over flush, accept and pop; reset mid-FULL SHALL discard both entries.

Structure
REQ-017 SHALL take the EX_WB typedef, NREGS and the opcode constants (NOP=144, CMP=57, IMUL=247, SYSCALL=5, CALL=232, GRP5=255, RET=195, PUSH/POP range, MOV_ST=137, MOV_LD=139, LEA=141, MOVI range) from the shared pipeline package, not local copies.
REQ-018 SHALL implement REQ-012 in one combinational sub-module, exwb_dst_decode, instantiated once per entry.

Verification
REQ-019 SHALL pass these directed scenarios:
  Single pass: EMPTY, ex_valid with opcode 139, regByte 3, wb_ready=1 -> can_writeback=1 next cycle; pending_dst bit 3 set for 1 cycle; then EMPTY.
  Backpressure: wb_ready=0, push A then B -> FULL, ex_ready=0. Raise wb_ready -> A then B on consecutive cycles, order preserved, exwb stable while stalled.
  Simultaneous: state ONE, accept and pop in the same cycle -> state stays ONE, exwb equals new data next cycle.
  Flush: in FULL, flush together with ex_valid -> EMPTY next cycle, pending_dst=0, new data dropped.
  Halt: accept entry with sim_end=1 while ex_valid stays high -> halted=1, ex_ready=0, held entry drains, no further accepts until reset.
  Reset in FULL, and mask decode: reset while FULL -> all outputs at reset values next cycle. Opcode 247 with regByte 1 -> mask bits 1 and 2; opcode 88 with rmByte 5 -> bits 4 and 5; opcode 137 with mod 0 -> 0.
